gate_arbiter: RTL and testbench

Sequencer for the single physical barrier gate that entering and exiting cars share. Entry and exit requests are latched, and simultaneous requests are arbitrated round-robin. Full-lot entries are refused. The gate is held open for a minimum dwell and kept open while a car is in the gate. Grant pulses go to the parking FSM, which owns spot and capacity bookkeeping.

---
 rtl/gate_arbiter_if.sv | 31 +++
 rtl/gate_arbiter.sv | 165 ++++++++++++++++
 tb/tb_gate_arbiter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/gate_arbiter_if.sv
// Request/grant bundle between the gate sensors, the parking FSM and the shared-gate arbiter.
interface gate_arbiter_if;
    logic       entry_req;
    logic       exit_req;
    logic [1:0] exit_slot;
    logic [3:0] spots;
    logic       full;
    logic       car_present;
    logic       entry_grant;
    logic       exit_grant;
    logic [1:0] grant_slot;
    logic       gate_open;
    logic       reject;
    logic       pend_entry;
    logic       pend_exit;
    logic [1:0] state;

    // Requester / parking-FSM side
    modport master (
        output entry_req, exit_req, exit_slot, spots, full, car_present,
        input  entry_grant, exit_grant, grant_slot, gate_open, reject,
               pend_entry, pend_exit, state
    );

    // Arbiter side
    modport slave (
        input  entry_req, exit_req, exit_slot, spots, full, car_present,
        output entry_grant, exit_grant, grant_slot, gate_open, reject,
               pend_entry, pend_exit, state
    );
endinterface

// File: rtl/gate_arbiter.sv
// Shared barrier-gate sequencer: latches entry/exit requests, arbitrates round-robin,
// refuses entries when full, and enforces open dwell, car-present hold and closed gap.
module gate_arbiter #(
    parameter int unsigned OPEN_CYCLES = 40_000_000,
    parameter int unsigned GAP_CYCLES  = 4_000_000,
    parameter int unsigned CNT_W       = 27
) (
    input  logic           clk,
    input  logic           reset,
    gate_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        OPEN  = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] OPEN_LAST = CNT_W'(OPEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_entry_q, pend_entry_d;
    logic             pend_exit_q, pend_exit_d;
    logic [1:0]       exit_slot_q, exit_slot_d;
    logic             last_exit_q, last_exit_d;
    logic             entry_grant_q, entry_grant_d;
    logic             exit_grant_q, exit_grant_d;
    logic             reject_q, reject_d;
    logic [1:0]       grant_slot_q, grant_slot_d;
    logic             gate_open_q, gate_open_d;

    logic             clr_entry;
    logic             clr_exit;
    logic             pick_exit;
    logic             exit_ok;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, arbitration, dwell counting and request latching
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_exit_d   = last_exit_q;
        grant_slot_d  = grant_slot_q;
        entry_grant_d = 1'b0;
        exit_grant_d  = 1'b0;
        reject_d      = 1'b0;
        clr_entry     = 1'b0;
        clr_exit      = 1'b0;
        pick_exit     = 1'b0;
        pend_entry_d  = pend_entry_q;
        pend_exit_d   = pend_exit_q;
        exit_slot_d   = exit_slot_q;
        exit_ok       = bus.exit_req && bus.spots[bus.exit_slot];

        case (state_q)
            IDLE: begin
                if (pend_entry_q || pend_exit_q) begin
                    // On a tie serve the type opposite to the one served last
                    pick_exit = pend_exit_q && (!pend_entry_q || !last_exit_q);
                    if (pick_exit) begin
                        state_d      = GRANT;
                        exit_grant_d = 1'b1;
                        grant_slot_d = exit_slot_q;
                        last_exit_d  = 1'b1;
                        clr_exit     = 1'b1;
                    end else if (bus.full) begin
                        reject_d  = 1'b1;
                        clr_entry = 1'b1;
                    end else begin
                        state_d       = GRANT;
                        entry_grant_d = 1'b1;
                        grant_slot_d  = 2'd0;
                        last_exit_d   = 1'b0;
                        clr_entry     = 1'b1;
                    end
                end
            end
            GRANT: begin
                state_d = OPEN;
                cnt_d   = '0;
            end
            OPEN: begin
                // A car under the barrier holds the gate open; the counter saturates meanwhile
                if (cnt_q >= OPEN_LAST && !bus.car_present) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else if (cnt_q < OPEN_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q >= GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // A new request at the same edge as its clear wins and stays queued
        pend_entry_d = bus.entry_req | (pend_entry_q & ~clr_entry);

        if (exit_ok && (!pend_exit_q || clr_exit)) begin
            pend_exit_d = 1'b1;
            exit_slot_d = bus.exit_slot;
        end else if (clr_exit) begin
            pend_exit_d = 1'b0;
        end

        gate_open_d = (state_d == OPEN);
    end

    // Registered datapath and outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q         <= '0;
            pend_entry_q  <= 1'b0;
            pend_exit_q   <= 1'b0;
            exit_slot_q   <= 2'd0;
            last_exit_q   <= 1'b0;
            entry_grant_q <= 1'b0;
            exit_grant_q  <= 1'b0;
            reject_q      <= 1'b0;
            grant_slot_q  <= 2'd0;
            gate_open_q   <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            pend_entry_q  <= pend_entry_d;
            pend_exit_q   <= pend_exit_d;
            exit_slot_q   <= exit_slot_d;
            last_exit_q   <= last_exit_d;
            entry_grant_q <= entry_grant_d;
            exit_grant_q  <= exit_grant_d;
            reject_q      <= reject_d;
            grant_slot_q  <= grant_slot_d;
            gate_open_q   <= gate_open_d;
        end
    end

    assign bus.entry_grant = entry_grant_q;
    assign bus.exit_grant  = exit_grant_q;
    assign bus.reject      = reject_q;
    assign bus.grant_slot  = grant_slot_q;
    assign bus.gate_open   = gate_open_q;
    assign bus.pend_entry  = pend_entry_q;
    assign bus.pend_exit   = pend_exit_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_gate_arbiter.sv
// Directed bench for gate_arbiter with short dwell/gap values and hand-derived cycle timing.
module tb_gate_arbiter;

    localparam int unsigned OPEN = 8;
    localparam int unsigned GAP  = 3;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    gate_arbiter_if bus ();

    gate_arbiter #(
        .OPEN_CYCLES (OPEN),
        .GAP_CYCLES  (GAP),
        .CNT_W       (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.entry_req   = 1'b0;
        bus.exit_req    = 1'b0;
        bus.exit_slot   = 2'd0;
        bus.spots       = 4'b0000;
        bus.full        = 1'b0;
        bus.car_present = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        #3 reset = 1'b1;
        step();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.state != 2'd0 && n < 50) begin
            step();
            n++;
        end
        check("wait_idle", bus.state, 0);
    endtask

    // Grants are mutually exclusive and never coincide with a reject
    always @(negedge clk) begin
        if (reset) begin
            check("exclusive",
                  (bus.entry_grant & bus.exit_grant) |
                  (bus.reject & (bus.entry_grant | bus.exit_grant)), 0);
        end
    end

    initial begin
        int open_cnt;
        int n;
        int seen;
        tests = 0;
        fails = 0;
        clear_inputs();
        reset = 1'b1;
        #2 reset = 1'b0;
        #21 reset = 1'b1;
        step();

        check("rst_state", bus.state, 0);
        check("rst_gate", bus.gate_open, 0);
        check("rst_pend", {bus.pend_entry, bus.pend_exit}, 0);
        check("rst_slot", bus.grant_slot, 0);

        // Single entry
        bus.entry_req = 1'b1;
        step();
        bus.entry_req = 1'b0;
        check("t1_pend_E", bus.pend_entry, 1);
        check("t1_grant_E", bus.entry_grant, 0);
        step();
        check("t1_grant_E1", bus.entry_grant, 1);
        check("t1_state_E1", bus.state, 1);
        check("t1_pend_E1", bus.pend_entry, 0);
        check("t1_gate_E1", bus.gate_open, 0);
        step();
        check("t1_grant_E2", bus.entry_grant, 0);
        check("t1_gate_E2", bus.gate_open, 1);
        check("t1_state_E2", bus.state, 2);
        open_cnt = 1;
        for (int k = 3; k <= 13; k++) begin
            step();
            open_cnt += int'(bus.gate_open);
            if (k == 9)  check("t1_state_E9", bus.state, 2);
            if (k == 10) check("t1_state_E10", bus.state, 3);
            if (k == 12) check("t1_state_E12", bus.state, 3);
            if (k == 13) check("t1_state_E13", bus.state, 0);
        end
        check("t1_open_cycles", open_cnt, 8);

        // Simultaneous entry and exit after reset: exit first
        do_reset();
        bus.spots     = 4'b0100;
        bus.entry_req = 1'b1;
        bus.exit_req  = 1'b1;
        bus.exit_slot = 2'd2;
        step();
        bus.entry_req = 1'b0;
        bus.exit_req  = 1'b0;
        bus.exit_slot = 2'd0;
        check("t2_pend_both", {bus.pend_entry, bus.pend_exit}, 3);
        step();
        check("t2_exit_grant", bus.exit_grant, 1);
        check("t2_entry_grant", bus.entry_grant, 0);
        check("t2_slot", bus.grant_slot, 2);
        check("t2_pend_after", {bus.pend_entry, bus.pend_exit}, 2);
        n = 0;
        while (!bus.entry_grant && n < 40) begin
            step();
            n++;
            if (n == 6) check("t2_slot_hold", bus.grant_slot, 2);
        end
        check("t2_entry_delay", n, 13);
        check("t2_entry_slot", bus.grant_slot, 0);
        check("t2_entry_state", bus.state, 1);
        wait_idle();

        // Entry refused when full
        bus.full      = 1'b1;
        bus.entry_req = 1'b1;
        step();
        bus.entry_req = 1'b0;
        check("t3_pend_E", bus.pend_entry, 1);
        step();
        check("t3_reject", bus.reject, 1);
        check("t3_no_grant", bus.entry_grant, 0);
        check("t3_pend", bus.pend_entry, 0);
        check("t3_state", bus.state, 0);
        step();
        check("t3_reject_end", bus.reject, 0);
        check("t3_gate", bus.gate_open, 0);
        check("t3_state2", bus.state, 0);
        bus.full = 1'b0;

        // Car present holds the gate open past the dwell
        bus.car_present = 1'b1;
        bus.entry_req   = 1'b1;
        step();
        bus.entry_req = 1'b0;
        step();
        step();
        for (int k = 3; k <= 21; k++) begin
            step();
            if (k == 12) check("t4_hold_gate", bus.gate_open, 1);
            if (k == 12) check("t4_hold_state", bus.state, 2);
        end
        check("t4_gate_E21", bus.gate_open, 1);
        bus.car_present = 1'b0;
        step();
        check("t4_gate_E22", bus.gate_open, 0);
        check("t4_state_E22", bus.state, 3);
        step();
        step();
        check("t4_state_E24", bus.state, 3);
        step();
        check("t4_state_E25", bus.state, 0);

        // Exit for an empty slot is ignored
        bus.spots     = 4'b0000;
        bus.exit_req  = 1'b1;
        bus.exit_slot = 2'd1;
        step();
        bus.exit_req  = 1'b0;
        bus.exit_slot = 2'd0;
        check("t5_pend", bus.pend_exit, 0);
        step();
        check("t5_grant", bus.exit_grant, 0);
        check("t5_state", bus.state, 0);
        step();
        check("t5_gate", bus.gate_open, 0);

        // Asynchronous reset during OPEN with a queued entry
        bus.entry_req = 1'b1;
        step();
        bus.entry_req = 1'b0;
        step();
        step();
        step();
        bus.entry_req = 1'b1;
        step();
        bus.entry_req = 1'b0;
        check("t6_pend_open", bus.pend_entry, 1);
        check("t6_state_open", bus.state, 2);
        #2 reset = 1'b0;
        #1;
        check("t6_rst_gate", bus.gate_open, 0);
        check("t6_rst_pend", bus.pend_entry, 0);
        check("t6_rst_state", bus.state, 0);
        #2 reset = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            seen += int'(bus.entry_grant | bus.exit_grant | bus.gate_open);
        end
        check("t6_no_grant", seen, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
